// File: rtl/opb_register_simulink2ppc_coherent_if.sv
// OPB bus-side signals of the simulink2ppc coherent readback register.
// The master modport is used by the bus/testbench, the slave modport by the register.
interface opb_register_simulink2ppc_coherent_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc_coherent.sv
// Read-only OPB register exposing a user-written value of up to 64 bits; reading the
// low word snapshots the high word. Optional update counter: SIM2PPC_UPDATE_CNT_EN.
module opb_register_simulink2ppc_coherent #(
    parameter logic [31:0] C_BASEADDR   = 32'h01084100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010841FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int unsigned C_USER_WIDTH = 64
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    opb_register_simulink2ppc_coherent_if.slave opb,
    input  logic [C_USER_WIDTH-1:0] user_data_in,
    input  logic                    user_data_we
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    localparam int unsigned unused_family_len = $bits(C_FAMILY);

    bus_state_t              state;
    logic [63:0]             data_reg;
    logic [31:0]             shadow_hi;
    logic                    new_flag;
    logic [63:0]             user_ext;
    logic [C_OPB_AWIDTH-1:0] addr;
    logic [1:0]              word_off;
    logic                    in_range;
    logic                    hit;
    logic                    rd_lo;
    logic [C_OPB_DWIDTH-1:0] rd_word;
    logic                    unused_inputs;

`ifdef SIM2PPC_UPDATE_CNT_EN
    logic [31:0]             upd_cnt;
`endif

    assign addr          = opb.OPB_ABus;
    assign word_off      = opb.OPB_ABus[28:29];
    assign in_range      = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign hit           = opb.OPB_select && in_range && (state == ST_IDLE);
    assign rd_lo         = hit && opb.OPB_RNW && (word_off == 2'd0);
    assign unused_inputs = ^{opb.OPB_BE, opb.OPB_DBus, opb.OPB_seqAddr};

    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    always_comb begin
        user_ext                     = '0;
        user_ext[C_USER_WIDTH-1:0]   = user_data_in;
    end

    always_comb begin
        rd_word = '0;
        unique case (word_off)
            2'd0: rd_word = data_reg[31:0];
            2'd1: rd_word = shadow_hi;
`ifdef SIM2PPC_UPDATE_CNT_EN
            2'd2: rd_word = upd_cnt;
`else
            2'd2: rd_word = '0;
`endif
            2'd3: rd_word = {31'b0, new_flag};
            default: rd_word = '0;
        endcase
    end

    // Capture and snapshot share an edge: the read sees the old pair, and a new capture
    // re-arms new_flag even when the same edge consumes it.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_reg   <= '0;
            shadow_hi  <= '0;
            new_flag   <= 1'b0;
        end else begin
            if (user_data_we) begin
                data_reg <= user_ext;
            end
            if (rd_lo) begin
                shadow_hi <= data_reg[63:32];
            end
            if (user_data_we) begin
                new_flag <= 1'b1;
            end else if (rd_lo) begin
                new_flag <= 1'b0;
            end
        end
    end

`ifdef SIM2PPC_UPDATE_CNT_EN
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            upd_cnt <= '0;
        end else if (user_data_we) begin
            upd_cnt <= upd_cnt + 32'd1;
        end
    end
`endif

    // One-cycle ack; the ACK state blocks re-decode so a held select is acked every other cycle.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state          <= ST_IDLE;
            opb.Sl_xferAck <= 1'b0;
            opb.Sl_DBus    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state          <= ST_ACK;
                        opb.Sl_xferAck <= 1'b1;
                        opb.Sl_DBus    <= opb.OPB_RNW ? rd_word : '0;
                    end else begin
                        opb.Sl_xferAck <= 1'b0;
                        opb.Sl_DBus    <= '0;
                    end
                end
                ST_ACK: begin
                    state          <= ST_IDLE;
                    opb.Sl_xferAck <= 1'b0;
                    opb.Sl_DBus    <= '0;
                end
                default: begin
                    state          <= ST_IDLE;
                    opb.Sl_xferAck <= 1'b0;
                    opb.Sl_DBus    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc_coherent.sv
// Directed bench for opb_register_simulink2ppc_coherent: handshake timing, coherent
// snapshot, capture/read collision, window decode, reset and the 0x8 word.
module tb_opb_register_simulink2ppc_coherent;

    localparam logic [31:0] BASE = 32'h01084100;
    localparam logic [31:0] HIGH = 32'h010841FF;

    logic        clk;
    logic        rst;
    logic [63:0] user_data_in;
    logic        user_data_we;
    int          total;
    int          bad;

    opb_register_simulink2ppc_coherent_if bus ();

    opb_register_simulink2ppc_coherent #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex5"),
        .C_USER_WIDTH (64)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .opb          (bus.slave),
        .user_data_in (user_data_in),
        .user_data_we (user_data_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.OPB_select = 1'b0;
        bus.OPB_ABus   = '0;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_DBus   = '0;
    endtask

    // Select driven at a negedge, ack expected after the next posedge and gone one cycle later.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic rnw,
                        input logic [31:0] wdata, input logic [31:0] exp_data);
        @(negedge clk);
        chk({tag, "_pre_ack"}, {31'b0, bus.Sl_xferAck}, 32'd0);
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = wdata;
        @(posedge clk);
        #1;
        chk({tag, "_ack"}, {31'b0, bus.Sl_xferAck}, 32'd1);
        if (rnw) chk({tag, "_data"}, bus.Sl_DBus, exp_data);
        bus_idle();
        @(posedge clk);
        #1;
        chk({tag, "_ack_drop"}, {31'b0, bus.Sl_xferAck}, 32'd0);
        chk({tag, "_dbus_idle"}, bus.Sl_DBus, 32'd0);
    endtask

    task automatic capture(input logic [63:0] val);
        @(negedge clk);
        user_data_in = val;
        user_data_we = 1'b1;
        @(negedge clk);
        user_data_we = 1'b0;
    endtask

    task automatic no_ack(input string tag, input logic [31:0] addr);
        @(negedge clk);
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ack"}, {31'b0, bus.Sl_xferAck}, 32'd0);
        bus_idle();
        @(posedge clk);
        #1;
        chk({tag, "_ack2"}, {31'b0, bus.Sl_xferAck}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        user_data_in = '0;
        user_data_we = 1'b0;
        bus.OPB_BE      = 4'hF;
        bus.OPB_seqAddr = 1'b0;
        bus_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, bus.Sl_xferAck}, 32'd0);
        chk("rst_dbus", bus.Sl_DBus, 32'd0);
        chk("rst_erracks", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // After reset every word reads zero
        xfer("t1_r0", BASE + 32'h0, 1'b1, '0, 32'h0);
        xfer("t1_r4", BASE + 32'h4, 1'b1, '0, 32'h0);
        xfer("t1_r8", BASE + 32'h8, 1'b1, '0, 32'h0);
        xfer("t1_rC", BASE + 32'hC, 1'b1, '0, 32'h0);

        // Capture, flag, snapshot-not-live
        capture(64'h89ABCDEF_01234567);
        xfer("t2_flag_set",   BASE + 32'hC, 1'b1, '0, 32'h1);
        xfer("t2_lo",         BASE + 32'h0, 1'b1, '0, 32'h01234567);
        xfer("t2_flag_clr",   BASE + 32'hC, 1'b1, '0, 32'h0);
        xfer("t2_shadow",     BASE + 32'h4, 1'b1, '0, 32'h89ABCDEF);
        capture(64'h11111111_22222222);
        xfer("t2_shadow_old", BASE + 32'h4, 1'b1, '0, 32'h89ABCDEF);
        xfer("t2_flag_again", BASE + 32'hC, 1'b1, '0, 32'h1);

        // Capture in the same cycle as the low-word decode
        @(negedge clk);
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = BASE;
        bus.OPB_RNW    = 1'b1;
        user_data_in   = 64'h33333333_44444444;
        user_data_we   = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_ack", {31'b0, bus.Sl_xferAck}, 32'd1);
        chk("t3_old_lo", bus.Sl_DBus, 32'h22222222);
        user_data_we = 1'b0;
        bus_idle();
        @(posedge clk);
        #1;
        chk("t3_ack_drop", {31'b0, bus.Sl_xferAck}, 32'd0);
        xfer("t3_old_hi",  BASE + 32'h4, 1'b1, '0, 32'h11111111);
        xfer("t3_flag",    BASE + 32'hC, 1'b1, '0, 32'h1);
        xfer("t3_new_lo",  BASE + 32'h0, 1'b1, '0, 32'h44444444);
        xfer("t3_new_hi",  BASE + 32'h4, 1'b1, '0, 32'h33333333);
        xfer("t3_flag_clr", BASE + 32'hC, 1'b1, '0, 32'h0);

        // Select held six cycles: acks after the 1st, 3rd and 5th edges
        @(negedge clk);
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = BASE + 32'h4;
        bus.OPB_RNW    = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t4_ack_c%0d", i + 1), {31'b0, bus.Sl_xferAck}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t4_dbus_c%0d", i + 1), bus.Sl_DBus, (i % 2 == 1) ? 32'h33333333 : 32'h0);
        end
        bus_idle();
        @(posedge clk);
        #1;
        chk("t4_ack_after", {31'b0, bus.Sl_xferAck}, 32'd0);

        // Writes are acked but change nothing; window edges
        capture(64'h55555555_66666666);
        xfer("t5_wr0",      BASE + 32'h0, 1'b0, 32'hFFFFFFFF, 32'h0);
        xfer("t5_flag_kept", BASE + 32'hC, 1'b1, '0, 32'h1);
        xfer("t5_shadow_kept", BASE + 32'h4, 1'b1, '0, 32'h33333333);
        xfer("t5_lo",       BASE + 32'h0, 1'b1, '0, 32'h66666666);
        xfer("t5_wrap_hi",  BASE + 32'h14, 1'b1, '0, 32'h55555555);
        xfer("t5_highaddr", HIGH, 1'b1, '0, 32'h0);
        no_ack("t5_above", HIGH + 32'h1);
        no_ack("t5_below", BASE - 32'h1);

`ifdef SIM2PPC_UPDATE_CNT_EN
        @(negedge clk);
        dut.upd_cnt = 32'hFFFFFFFE;
        capture(64'h1);
        capture(64'h2);
        capture(64'h3);
        xfer("t6_cnt_wrap", BASE + 32'h8, 1'b1, '0, 32'h00000001);
`else
        capture(64'h1);
        xfer("t6_off8_zero", BASE + 32'h8, 1'b1, '0, 32'h0);
`endif

        // Reset during the ack cycle drops the ack and clears the register
        @(negedge clk);
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = BASE + 32'h4;
        bus.OPB_RNW    = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ack_before_rst", {31'b0, bus.Sl_xferAck}, 32'd1);
        rst = 1'b1;
        bus_idle();
        @(posedge clk);
        #1;
        chk("t6_ack_after_rst", {31'b0, bus.Sl_xferAck}, 32'd0);
        chk("t6_dbus_after_rst", bus.Sl_DBus, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        xfer("t6_lo_after_rst",   BASE + 32'h0, 1'b1, '0, 32'h0);
        xfer("t6_flag_after_rst", BASE + 32'hC, 1'b1, '0, 32'h0);
        xfer("t6_hi_after_rst",   BASE + 32'h4, 1'b1, '0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog observed=timeout expected=finish");
    end

endmodule
